interval_timer: RTL

INTERVAL_TIMER -- requirements
Module: interval_timer

---
 rtl/traffic_timing_pkg.sv | 24 ++
 rtl/tick_divider.sv | 30 +++
 rtl/interval_timer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/traffic_timing_pkg.sv
// Shared encodings, default interval lengths and FSM state type for the interval timer.
// The walk interval encoding is only honoured when INTERVAL_WALK_EN is defined.
package traffic_timing_pkg;

  localparam int TIME_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    SEL_BASE = 2'b00,
    SEL_EXT  = 2'b01,
    SEL_YEL  = 2'b10,
    SEL_WALK = 2'b11
  } interval_sel_e;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;
  localparam int DEF_T_WALK = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } timer_state_e;

endpackage

// File: rtl/tick_divider.sv
// Prescaler producing one tick every CLK_DIV cycles while run is high.
// Holds at zero whenever the timer is idle or a countdown is (re)started.
module tick_divider #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || clear || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/interval_timer.sv
// Programmable interval countdown timer with four (three without INTERVAL_WALK_EN)
// parameter registers and a one-cycle expired pulse.
module interval_timer
  import traffic_timing_pkg::*;
#(
  parameter int CLK_DIV = 100,
  parameter int TIME_W  = TIME_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_timer,
  input  logic [1:0]        interval,
  input  logic              prog_sync,
  input  logic [1:0]        param_sel,
  input  logic [TIME_W-1:0] time_value,
  output logic              expired,
  output logic              busy,
  output logic [TIME_W-1:0] time_left
);

  timer_state_e state, next_state;

  logic [TIME_W-1:0] t_base, t_ext, t_yel;
`ifdef INTERVAL_WALK_EN
  logic [TIME_W-1:0] t_walk;
`endif
  logic [TIME_W-1:0] sel_value;
  logic [TIME_W-1:0] prog_value;
  logic              tick;
  logic              final_tick;

  tick_divider #(.CLK_DIV(CLK_DIV)) u_tick_divider (
    .clk   (clk),
    .reset (reset),
    .clear (start_timer),
    .run   (state == ST_RUN),
    .tick  (tick)
  );

  always_comb begin
    sel_value = t_base;
    case (interval)
      SEL_EXT:  sel_value = t_ext;
      SEL_YEL:  sel_value = t_yel;
`ifdef INTERVAL_WALK_EN
      SEL_WALK: sel_value = t_walk;
`endif
      default:  sel_value = t_base;
    endcase
  end

  // A zero interval would never expire, so it is stored as a single tick.
  assign prog_value = (time_value == '0) ? TIME_W'(1) : time_value;

  always_ff @(posedge clk) begin
    if (!reset) begin
      t_base <= TIME_W'(DEF_T_BASE);
      t_ext  <= TIME_W'(DEF_T_EXT);
      t_yel  <= TIME_W'(DEF_T_YEL);
`ifdef INTERVAL_WALK_EN
      t_walk <= TIME_W'(DEF_T_WALK);
`endif
    end else if (prog_sync) begin
      case (param_sel)
        SEL_BASE: t_base <= prog_value;
        SEL_EXT:  t_ext  <= prog_value;
        SEL_YEL:  t_yel  <= prog_value;
`ifdef INTERVAL_WALK_EN
        SEL_WALK: t_walk <= prog_value;
`endif
        default: ;
      endcase
    end
  end

  assign final_tick = (state == ST_RUN) && tick && (time_left == TIME_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (start_timer) next_state = ST_RUN;
      ST_RUN: begin
        if (start_timer) begin
          next_state = ST_RUN;
        end else if (final_tick) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // A restart outranks the final tick, so the aborted count never pulses expired.
  always_ff @(posedge clk) begin
    if (!reset) begin
      time_left <= '0;
      expired   <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (start_timer) begin
        time_left <= sel_value;
      end else if (final_tick) begin
        time_left <= '0;
        expired   <= 1'b1;
      end else if ((state == ST_RUN) && tick) begin
        time_left <= time_left - TIME_W'(1);
      end
    end
  end

endmodule
